// File: rtl/ex_pkg.sv
// ex_pkg -- opcode/funct constants, FSM states and mul/div op encoding (rev 1.0)
`default_nettype none

package ex_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, FIX = 2'd2} state_t;

  // Order matches funct[1:0] of MULT/MULTU/DIV/DIVU.
  typedef enum logic [1:0] {MD_MULT = 2'd0, MD_MULTU = 2'd1, MD_DIV = 2'd2, MD_DIVU = 2'd3} md_op_t;

endpackage

`default_nettype wire

// File: rtl/ex_stage_mc_if.sv
// ex_stage_mc_if -- decode-side and memory-side handshakes of the execute stage (rev 1.0)
`default_nettype none

interface ex_stage_mc_if #(
  parameter int WIDTH = 32,
  parameter int PCW   = 32
);
  logic [31:0]      Ins;
  logic [WIDTH-1:0] Rdata1;
  logic [WIDTH-1:0] Rdata2;
  logic [WIDTH-1:0] Ed32;
  logic [PCW-1:0]   nextPC;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] Result;
  logic [PCW-1:0]   newPC;
  logic             Illegal;
  logic             OutValid;
  logic             OutReady;

  modport master (
    output Ins, Rdata1, Rdata2, Ed32, nextPC, InValid, OutReady,
    input  InReady, Result, newPC, Illegal, OutValid
  );

  modport slave (
    input  Ins, Rdata1, Rdata2, Ed32, nextPC, InValid, OutReady,
    output InReady, Result, newPC, Illegal, OutValid
  );
endinterface

`default_nettype wire

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq -- one-bit-per-cycle shift-add multiplier / restoring divider (rev 1.0)
`default_nettype none

module ex_muldiv_seq
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  md_op_t           Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q;
  md_op_t           op_q;
  logic             negp_q, negr_q, dz_q;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, a_orig_q;

  logic             sgn_in, div_in, a_neg, b_neg, op_div;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   sum, shifted, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rmd;

  assign sgn_in = (Op == MD_MULT) || (Op == MD_DIV);
  assign div_in = (Op == MD_DIV) || (Op == MD_DIVU);
  assign a_neg  = sgn_in && A[WIDTH-1];
  assign b_neg  = sgn_in && B[WIDTH-1];
  assign mag_a  = a_neg ? (~A + 1'b1) : A;
  assign mag_b  = b_neg ? (~B + 1'b1) : B;
  assign op_div = (op_q == MD_DIV) || (op_q == MD_DIVU);

  assign sum     = {1'b0, rem_q} + {1'b0, (lo_q[0] ? b_q : '0)};
  assign shifted = {rem_q, lo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, b_q};
  assign Done    = run_q && (cnt_q == CW'(WIDTH));

  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    lo_d  = lo_q;
    if (run_q && (cnt_q != CW'(WIDTH))) begin
      cnt_d = cnt_q + 1'b1;
      if (op_div) begin
        // rem < divisor, so diff[WIDTH] is a reliable borrow flag
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        rem_d = sum[WIDTH:1];
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    prod = {rem_q, lo_q};
    if (negp_q) prod = -prod;
    quo = negp_q ? -lo_q : lo_q;
    rmd = negr_q ? -rem_q : rem_q;
    if (!op_div) begin
      Hi = prod[2*WIDTH-1:WIDTH];
      Lo = prod[WIDTH-1:0];
    end else if (dz_q) begin
      Hi = a_orig_q;
      Lo = '1;
    end else begin
      Hi = rmd;
      Lo = quo;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= '0;
      run_q    <= 1'b0;
      op_q     <= MD_MULT;
      negp_q   <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      rem_q    <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      a_orig_q <= '0;
    end else if (Start) begin
      cnt_q    <= '0;
      run_q    <= 1'b1;
      op_q     <= Op;
      negp_q   <= a_neg ^ b_neg;
      negr_q   <= a_neg;
      dz_q     <= div_in && (B == '0);
      rem_q    <= '0;
      lo_q     <= mag_a;
      b_q      <= mag_b;
      a_orig_q <= A;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      lo_q  <= lo_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_stage_mc.sv
// ex_stage_mc -- multi-cycle MIPS execute stage with HI/LO and iterative mul/div (rev 1.0)
`default_nettype none

module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PCW   = 32
) (
  input logic          CLK,
  input logic          RST,
  ex_stage_mc_if.slave bus
);
  state_t           state_q;
  logic [WIDTH-1:0] hi_q, lo_q, result_q, result_d;
  logic [PCW-1:0]   newpc_q, newpc_d, mdpc_q;
  logic             illegal_q, illegal_d, valid_q;
  logic             is_md, taken, in_ready, accept, md_start;
  md_op_t           md_op;
  logic             md_done;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic [5:0]       opc, fn;
  logic [WIDTH-1:0] a, b, imm;
  logic [WIDTH+PCW-1:0] off_ext;
  logic             unused_bits;

  assign opc = bus.Ins[31:26];
  assign fn  = bus.Ins[5:0];
  assign a   = bus.Rdata1;
  assign b   = bus.Rdata2;
  assign imm = bus.Ed32;
  // Sign-extend before shifting so the offset is right for any PCW
  assign off_ext     = {{PCW{imm[WIDTH-1]}}, imm} << 2;
  assign unused_bits = ^{bus.Ins[25:6], off_ext[WIDTH+PCW-1:PCW]};

  always_comb begin
    result_d  = '0;
    illegal_d = 1'b0;
    taken     = 1'b0;
    is_md     = 1'b0;
    md_op     = md_op_t'(fn[1:0]);
    unique case (opc)
      OP_RTYPE: begin
        unique case (fn)
          FN_ADD:  result_d = a + b;
          FN_SUB:  result_d = a - b;
          FN_AND:  result_d = a & b;
          FN_OR:   result_d = a | b;
          FN_XOR:  result_d = a ^ b;
          FN_SLT:  result_d = WIDTH'($signed(a) < $signed(b));
          FN_SLTU: result_d = WIDTH'(a < b);
          FN_MFHI: result_d = hi_q;
          FN_MFLO: result_d = lo_q;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: is_md = 1'b1;
          default: illegal_d = 1'b1;
        endcase
      end
      OP_ADDI: result_d = a + imm;
      OP_SLTI: result_d = WIDTH'($signed(a) < $signed(imm));
      OP_ANDI: result_d = a & imm;
      OP_ORI:  result_d = a | imm;
      OP_XORI: result_d = a ^ imm;
      OP_BEQ: begin
        result_d = a - b;
        taken    = (a == b);
      end
      OP_BNE: begin
        result_d = a - b;
        taken    = (a != b);
      end
      default: illegal_d = 1'b1;
    endcase
    newpc_d = taken ? (bus.nextPC + off_ext[PCW-1:0]) : bus.nextPC;
  end

  assign in_ready = (state_q == IDLE) && (!valid_q || bus.OutReady);
  assign accept   = bus.InValid && in_ready;
  assign md_start = accept && is_md;

  ex_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .CLK   (CLK),
    .RST   (RST),
    .Start (md_start),
    .Op    (md_op),
    .A     (a),
    .B     (b),
    .Done  (md_done),
    .Hi    (md_hi),
    .Lo    (md_lo)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      newpc_q   <= '0;
      mdpc_q    <= '0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      if (valid_q && bus.OutReady) valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_md) begin
              state_q <= BUSY;
              mdpc_q  <= bus.nextPC;
            end else begin
              result_q  <= result_d;
              newpc_q   <= newpc_d;
              illegal_q <= illegal_d;
              valid_q   <= 1'b1;
            end
          end
        end
        BUSY: if (md_done) state_q <= FIX;
        FIX: begin
          // Output register is guaranteed empty here: accept required it free
          hi_q      <= md_hi;
          lo_q      <= md_lo;
          result_q  <= md_lo;
          newpc_q   <= mdpc_q;
          illegal_q <= 1'b0;
          valid_q   <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.InReady  = in_ready;
  assign bus.Result   = result_q;
  assign bus.newPC    = newpc_q;
  assign bus.Illegal  = illegal_q;
  assign bus.OutValid = valid_q;

endmodule

`default_nettype wire
